// File: rtl/uart_rx_byte_pkg.sv
// Purpose: shared UART constants and state encoding for the receiver (and a future transmitter).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_byte_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS    = 8;
  // 50 MHz core clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Purpose: serial line in, received byte and status strobes out.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take each byte on its strobe cycle.
interface uart_rx_byte_if;
  import uart_rx_byte_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] dataOut;
  logic                      newData;
  logic                      frameError;
  logic                      busy;

  // receiver side
  modport master (
    input  rx,
    output dataOut, newData, frameError, busy
  );

  // line driver / byte consumer side
  modport slave (
    output rx,
    input  dataOut, newData, frameError, busy
  );
endinterface

// File: rtl/uart_rx_byte_sync_2ff.sv
// Purpose: 1-bit two-flop synchroniser for asynchronous inputs, reset to a chosen level.
// Latency: 2 clk from input change to output change.
// Backpressure: none.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // two back-to-back flops; the first may go metastable, the second resolves it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// Purpose: 8N1 UART receiver; emits each good byte with a one-cycle newData strobe, flags bad stop bits.
// Latency: strobe visible 2 (sync) + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after rx falls.
// Backpressure: none; strobes are single-cycle and dataOut holds until the next good byte.
module uart_rx_byte
  import uart_rx_byte_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT   // must be >= 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_byte_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT_IDX  = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  rx_state_t                 state_nxt;
  logic [CNT_W-1:0]          cnt;
  logic [2:0]                bit_idx;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] data_out;
  logic                      new_data;
  logic                      frame_error;
  logic                      rxs;

  logic half_hit;
  logic bit_hit;
  logic cnt_clr;
  logic sample_bit;
  logic stop_good;
  logic stop_bad;

  // idle line level is high, so the synchroniser resets high to avoid a false start
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rxs)
  );

  assign half_hit = (cnt == CNT_HALF_LAST);
  assign bit_hit  = (cnt == CNT_BIT_LAST);

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  // next-state: a low at mid start bit confirms the frame, a high there was a glitch
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (!rxs)                             state_nxt = RX_START;
      RX_START: if (half_hit)                         state_nxt = rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_hit && bit_idx == LAST_BIT_IDX) state_nxt = RX_STOP;
      RX_STOP:  if (bit_hit)                          state_nxt = RX_IDLE;
      default:                                        state_nxt = RX_IDLE;
    endcase
  end

  // datapath controls decoded from state; busy is safe to use combinationally
  always_comb begin
    cnt_clr    = 1'b0;
    sample_bit = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    case (state)
      RX_IDLE:  cnt_clr = 1'b1;
      RX_START: cnt_clr = half_hit;
      RX_DATA: begin
        cnt_clr    = bit_hit;
        sample_bit = bit_hit;
      end
      RX_STOP: begin
        cnt_clr   = bit_hit;
        stop_good = bit_hit && rxs;
        stop_bad  = bit_hit && !rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  assign bus.busy = (state != RX_IDLE);

  // bit timing counter, bit index and the internal shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (state == RX_START) bit_idx <= '0;
      else if (sample_bit)   bit_idx <= bit_idx + 1'b1;
      if (sample_bit) shift[bit_idx] <= rxs;
    end
  end

  // registered outputs; dataOut only moves on a good stop bit so partial frames stay hidden
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      new_data    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      new_data    <= stop_good;
      frame_error <= stop_bad;
      if (stop_good) data_out <= shift;
    end
  end

  assign bus.dataOut    = data_out;
  assign bus.newData    = new_data;
  assign bus.frameError = frame_error;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Purpose: randomized and directed checks of uart_rx_byte against a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_byte;
  import uart_rx_byte_pkg::*;

  localparam int C    = 16;
  localparam int HALF = C / 2;
  // two synchroniser flops plus the IDLE edge that first sees the low level
  localparam int STROBE_LAT = 3 + HALF + 9 * C;
  localparam int FRAME_CLKS = 10 * C;
  // a held-low line re-arms one cycle after each error
  localparam int BREAK_PERIOD = HALF + 9 * C + 1;
  localparam int BREAK_BITS   = 40;

  localparam int EV_DATA = 1;
  localparam int EV_FERR = 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // observed strobes (from the monitor) and expected strobes (from the model)
  int         obs_kind[$];
  logic [7:0] obs_data[$];
  int         obs_cyc[$];
  int         exp_kind[$];
  logic [7:0] exp_data[$];
  logic [7:0] exp_dout;
  int         frame_start_cyc;

  bit         mon_en    = 1'b0;
  logic       busy_prev = 1'b0;
  logic       nd_prev   = 1'b0;
  logic       fe_prev   = 1'b0;
  logic [7:0] dout_prev = 8'h00;

  // monitor: record strobes and check per-strobe invariants
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (bus.newData || bus.frameError) begin
        obs_kind.push_back(bus.newData ? EV_DATA : EV_FERR);
        obs_data.push_back(bus.dataOut);
        obs_cyc.push_back(cyc);
        check("strobe_exclusive", 32'(bus.newData & bus.frameError), 0);
        check("strobe_one_cycle", 32'(nd_prev | fe_prev), 0);
        check("busy_falls_with_strobe", {30'd0, busy_prev, bus.busy}, 32'b10);
      end
      if (!bus.newData && bus.dataOut !== dout_prev)
        check("dout_stable", 32'(bus.dataOut), 32'(dout_prev));
    end
    busy_prev = bus.busy;
    nd_prev   = bus.newData;
    fe_prev   = bus.frameError;
    dout_prev = bus.dataOut;
  end

  task automatic drive_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(negedge clk);
  endtask

  // drives one 8N1 frame and predicts its outcome
  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    frame_start_cyc = cyc;
    drive_bit(1'b0, C);
    for (int i = 0; i < 8; i++) drive_bit(d[i], C);
    drive_bit(stop_ok, C);
    if (stop_ok) begin
      exp_dout = d;
      exp_kind.push_back(EV_DATA);
      exp_data.push_back(d);
    end else begin
      exp_kind.push_back(EV_FERR);
      exp_data.push_back(exp_dout);
    end
  endtask

  task automatic settle();
    int n = 0;
    while (bus.busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 400), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_events();
    obs_kind.delete(); obs_data.delete(); obs_cyc.delete();
    exp_kind.delete(); exp_data.delete();
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_count"}, obs_kind.size(), exp_kind.size());
    n = (obs_kind.size() < exp_kind.size()) ? obs_kind.size() : exp_kind.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_kind%0d", tag, i), obs_kind[i], exp_kind[i]);
      check($sformatf("%s_data%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
    end
    check({tag, "_dout"}, 32'(bus.dataOut), 32'(exp_dout));
    clear_events();
  endtask

  initial begin
    int nfe;
    int nnd;
    logic [7:0] b;
    logic       ok;
    int         gap;

    reset    = 1'b1;
    bus.rx   = 1'b1;
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout",  32'(bus.dataOut), 0);
    check("rst_nd",    32'(bus.newData), 0);
    check("rst_ferr",  32'(bus.frameError), 0);
    check("rst_busy",  32'(bus.busy), 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // single good byte, plus end-to-end latency
    send_frame(8'hA5, 1'b1);
    settle();
    check("a5_latency", (obs_cyc.size() > 0) ? obs_cyc[0] - frame_start_cyc : -1, STROBE_LAT);
    compare("a5");

    // short low glitch on an idle line
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check("glitch_busy", 32'(bus.busy), 0);
    compare("glitch");

    // bad stop bit
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b1, C);
    settle();
    compare("ferr");

    // back-to-back frames
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    settle();
    check("b2b_spacing", (obs_cyc.size() > 1) ? obs_cyc[1] - obs_cyc[0] : -1, FRAME_CLKS);
    compare("b2b");

    // reset in the middle of data bit 4 of 0x5A
    b = 8'h5A;
    drive_bit(1'b0, C);
    for (int i = 0; i < 4; i++) drive_bit(b[i], C);
    drive_bit(b[4], HALF);
    reset  = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    exp_dout = 8'h00;
    check("rst_mid_dout", 32'(bus.dataOut), 0);
    check("rst_mid_busy", 32'(bus.busy), 0);
    compare("rst_mid");
    repeat (C) @(negedge clk);
    send_frame(8'h81, 1'b1);
    settle();
    compare("after_rst");

    // break: line held low, errors repeat and carry the last good byte
    drive_bit(1'b0, BREAK_BITS * C);
    nfe = 0;
    nnd = 0;
    foreach (obs_kind[i]) begin
      if (obs_kind[i] == EV_FERR) nfe++;
      else nnd++;
      check($sformatf("break_data%0d", i), 32'(obs_data[i]), 32'(exp_dout));
    end
    check("break_ferr_count", nfe, (BREAK_BITS * C) / BREAK_PERIOD);
    check("break_nd_count", nnd, 0);
    bus.rx = 1'b1;
    settle();
    repeat (2 * C) @(negedge clk);
    clear_events();
    send_frame(8'h11, 1'b1);
    settle();
    compare("after_break");

    // randomized frames with random stop validity and inter-frame gaps
    for (int f = 0; f < 30; f++) begin
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 4) != 0);
      send_frame(b, ok);
      gap = ok ? $urandom_range(0, 40) : C + $urandom_range(0, 24);
      if (gap > 0) drive_bit(1'b1, gap);
    end
    drive_bit(1'b1, C);
    settle();
    compare("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop in case the stimulus itself stalls
  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver that sits directly upstream of the RAM loader.
- Deserialises 8N1 UART frames from the host programming link.
- Presents each received byte as `dataOut` with a one-cycle `newData` strobe. This matches the parallel byte/strobe format the loader consumes.
- Flags malformed frames so the bad byte is never forwarded.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 8.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- dataOut  output  8  last correctly received byte, LSB first on the wire.
- newData  output  1  one-cycle pulse: `dataOut` holds a fresh valid byte.
- frameError  output  1  one-cycle pulse: stop bit sampled low, byte discarded.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - State = IDLE; counters = 0.
  - dataOut = 0, newData = 0, frameError = 0, busy = 0.
  - Synchroniser flops reset to 1 (idle line level).
- Input conditioning: `rx` passes through a 2-flop synchroniser; `rxs` is the synchronised level. All decisions use `rxs` only.
- State machine (IDLE, START, DATA, STOP). `cnt` is the bit-timing counter; `bitIdx` is a 3-bit index.
  - IDLE:
    - On `rxs == 0`: go to START, `cnt = 0`.
  - START:
    - Count `cnt` up to CLKS_PER_BIT/2 - 1 (mid start bit).
    - At that point, if `rxs == 1`, the start was a glitch: return to IDLE with no outputs.
    - Otherwise `cnt = 0`, `bitIdx = 0`, go to DATA.
  - DATA:
    - At `cnt == CLKS_PER_BIT-1` (mid data bit), load `shift[bitIdx] = rxs` and set `cnt = 0`.
    - If `bitIdx == 7`, go to STOP; else `bitIdx` += 1.
  - STOP:
    - At `cnt == CLKS_PER_BIT-1` (mid stop bit):
      - If `rxs == 1`: `dataOut <= shift`, `newData <= 1`.
      - Else: `frameError <= 1`, `dataOut` unchanged.
    - Return to IDLE in the same edge.
- Output timing:
  - `newData` and `frameError` are registered and high for exactly one clk.
  - They are mutually exclusive.
- Latency:
  - Mid-stop sample occurs `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles after the first `rxs == 0` cycle in IDLE.
  - The strobe is visible the cycle after that edge.
- Back-to-back frames: returning to IDLE at mid-stop lets a start bit immediately following the stop bit be detected. There is no minimum inter-frame gap beyond half a bit.
- Line held low after a frame error: IDLE re-enters START immediately. The break condition repeats frameError once per ~10 bit times. This is acceptable and is not filtered.
- `dataOut` is stable between strobes. The shift register is internal, so partial frames are never visible on `dataOut`.
- Reset mid-frame: the frame is abandoned with no strobe. After reset release, reception resumes at the next falling edge of `rxs`.
- `busy` is combinational from state (`state != IDLE`), glitch-free because the state is registered.

Decomposition:
- Shared constants header holds:
  - State encodings RX_IDLE=2'd0, RX_START=2'd1, RX_DATA=2'd2, RX_STOP=2'd3.
  - UART_DATA_BITS = 8.
  - Default CLKS_PER_BIT, so a future uart_tx reuses them.
- One sub-module: `sync_2ff` (1-bit two-flop synchroniser with asynchronous reset and a reset-value parameter). Reused elsewhere for other asynchronous inputs.

Test Plan (CLKS_PER_BIT = 16 for simulation):
- Send 0xA5 (rx: 0,1,0,1,0,0,1,0,1,1, 16 clk per bit) -> `dataOut = 0xA5`, `newData` high one cycle, `frameError = 0`, `busy` falls the same cycle `newData` rises.
- Low glitch of 4 clk on idle rx -> returns to IDLE at mid start bit; `newData` and `frameError` stay 0; `dataOut` keeps its prior value.
- Frame 0x3C with stop bit driven 0, then line high -> `frameError` one-cycle pulse, `newData = 0`, `dataOut` unchanged from the previous byte.
- Back-to-back 0x00 then 0xFF with no idle gap -> two `newData` pulses 160 clk apart; `dataOut` equals 0x00 then 0xFF.
- Assert reset during data bit 4 of 0x5A, release, then send 0x81 -> no strobe for 0x5A; `dataOut = 0` after reset; 0x81 is received correctly.
- Hold rx low for 40 bit times -> `frameError` pulses repeat roughly every 10 bit times; no `newData`. Line high then 0x11 -> `dataOut = 0x11`.
